mem_port_arbiter: RTL

Arbitrates a single-ported unified instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester of the pipelined MIPS core. It sequences each memory transaction through a handshake and returns read data with done strobes. It produces the stall indications that the hazard logic folds into PCWrite/IF_ID_Write. It honours IF_Flush by draining, then discarding, an in-flight fetch.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IF fetch and MEM load/store
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, SERV_D, SERV_I, DRAIN} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic             d_elig, i_elig, grant_d, grant_i, starved;

  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

  always_comb begin
    state_next = state;
    // A requester still showing its done strobe has not yet dropped req.
    d_elig  = d_req & ~d_done;
    i_elig  = if_req & ~if_done & ~if_flush;
    starved = (starve_cnt == CNT_W'(STARVE_MAX));
    grant_i = (state == IDLE) & i_elig & (~d_elig | starved);
    grant_d = (state == IDLE) & d_elig & ~grant_i;
    case (state)
      IDLE: begin
        if (grant_d)      state_next = SERV_D;
        else if (grant_i) state_next = SERV_I;
      end
      SERV_D: if (mem_ready) state_next = IDLE;
      SERV_I: begin
        if (mem_ready)     state_next = IDLE;
        else if (if_flush) state_next = DRAIN;
      end
      DRAIN:  if (mem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
    end else begin
      state   <= state_next;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (i_elig && !starved) starve_cnt <= starve_cnt + CNT_W'(1);
      end
      if (grant_i) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        starve_cnt <= '0;
      end
      if (state != IDLE && mem_ready) mem_req <= 1'b0;
      if (state == SERV_D && mem_ready) begin
        d_done <= 1'b1;
        if (!mem_we) d_rdata <= mem_rdata;
      end
      // Flush on the completing edge discards the fetch just like DRAIN does.
      if (state == SERV_I && mem_ready && !if_flush) begin
        if_done  <= 1'b1;
        if_rdata <= mem_rdata;
      end
    end
  end

endmodule
